// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the ALU_function encodings (shared with the ALU control decoder),
// the sequencer state encoding and the shift-amount width derivation.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  // Shift-amount width for a given operand width.
  function automatic int unsigned shw_for(input int unsigned width);
    return $clog2(width);
  endfunction

  localparam int unsigned ALU_SHW = shw_for(ALU_WIDTH);

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_OR    = 2'b10,
    ALU_SHIFT = 2'b11
  } alu_func_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: ADD, SUB, OR with signed overflow.
// Ports:
//   func : operation code (SHIFT yields zero; shifts are sequenced elsewhere)
//   a, b : operands
//   y    : result, modulo 2^WIDTH
//   ovf  : signed overflow, only for ADD/SUB
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  alu_func_e        func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (func)
      ALU_ADD: begin
        y   = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        y   = a + ~b + WIDTH'(1);
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_OR: begin
        y = a | b;
      end
      default: begin
        y   = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequenced ALU: ADD/SUB/OR in one cycle, logical left shift iterated one
// bit per cycle behind a start/busy/done handshake.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : request, sampled only while busy=0
//   ALU_function  : 00 ADD, 01 SUB, 10 OR, 11 SHIFT
//   src1, src2    : operands; src2[SHW-1:0] is the shift amount
//   busy          : high while a shift is iterating
//   done          : one-cycle completion pulse
//   result        : registered result
//   zero          : registered result==0 flag
//   overflow      : registered signed overflow (ADD/SUB)
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SHW   = shw_for(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       ALU_function,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  alu_func_e        func;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] core_y;
  logic             core_ovf;

  assign func  = alu_func_e'(ALU_function);
  assign shamt = src2[SHW-1:0];

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .func (func),
    .a    (src1),
    .b    (src2),
    .y    (core_y),
    .ovf  (core_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (func == ALU_SHIFT) begin
            if (shamt == '0) begin
              result_d = src1;
              zero_d   = (src1 == '0);
              ovf_d    = 1'b0;
              done_d   = 1'b1;
            end else begin
              acc_d   = src1;
              cnt_d   = shamt;
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = core_y;
            zero_d   = (core_y == '0);
            ovf_d    = core_ovf;
            done_d   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - SHW'(1);
        // Last iteration: publish the final shifted value directly rather
        // than waiting a cycle for acc to settle.
        if (cnt_q == SHW'(1)) begin
          result_d = acc_q << 1;
          zero_d   = ((acc_q << 1) == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: behavioural model compared every
// cycle, directed literal checks, then randomized traffic.
module tb_alu_seq_unit;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_OR    = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  fn;
  logic [31:0] src1, src2;
  logic        busy, done, zero, overflow;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ALU_function(fn),
    .src1        (src1),
    .src2        (src2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;
  logic        m_zero   = 1'b0;
  logic        m_ovf    = 1'b0;
  logic        m_done   = 1'b0;
  int          m_rem    = 0;
  longint      m_s;
  int          m_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result = '0; m_zero = 1'b0; m_ovf = 1'b0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_result = m_pend; m_zero = (m_pend == 0); m_ovf = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        case (fn)
          OP_ADD: begin
            m_s = longint'($signed(src1)) + longint'($signed(src2));
            m_result = src1 + src2;
            m_ovf = (m_s > SMAX) || (m_s < SMIN);
            m_zero = (m_result == 0); m_done = 1'b1;
          end
          OP_SUB: begin
            m_s = longint'($signed(src1)) - longint'($signed(src2));
            m_result = src1 - src2;
            m_ovf = (m_s > SMAX) || (m_s < SMIN);
            m_zero = (m_result == 0); m_done = 1'b1;
          end
          OP_OR: begin
            m_result = src1 | src2; m_ovf = 1'b0;
            m_zero = (m_result == 0); m_done = 1'b1;
          end
          default: begin
            m_k = int'(src2 % 32);
            if (m_k == 0) begin
              m_result = src1; m_ovf = 1'b0;
              m_zero = (m_result == 0); m_done = 1'b1;
            end else begin
              m_rem = m_k; m_pend = src1 << m_k;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    n_checks++;
    if (busy === (m_rem > 0) && done === m_done && result === m_result &&
        zero === m_zero && overflow === m_ovf)
      n_pass++;
    else
      $display("FAIL model_cmp t=%0t: busy %b/%b done %b/%b result %h/%h zero %b/%b ovf %b/%b",
               $time, busy, (m_rem > 0), done, m_done, result, m_result,
               zero, m_zero, overflow, m_ovf);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Returns just after the accepting edge E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; fn = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // cycles = index of the first negedge after E0 showing done (1 = next cycle).
  task automatic wait_done(input int max, output int cycles, output int busy_cnt);
    bit ok;
    ok = 0; cycles = 0; busy_cnt = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin cycles = i; ok = 1; break; end
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  int cyc, bcnt, dcnt;

  initial begin
    rst_n = 1'b0; start = 1'b0; fn = 2'b00; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // ADD 5+3
    issue(OP_ADD, 32'd5, 32'd3);
    wait_done(10, cyc, bcnt);
    chk("add_lat", cyc, 32'd1);
    chk("add_res", result, 32'd8);
    chk("add_zero", 32'(zero), 32'd0);
    chk("add_ovf", 32'(overflow), 32'd0);
    chk("add_busy", bcnt, 32'd0);

    // SUB overflow, then SUB to zero
    issue(OP_SUB, 32'h80000000, 32'd1);
    wait_done(10, cyc, bcnt);
    chk("sub_res", result, 32'h7FFFFFFF);
    chk("sub_ovf", 32'(overflow), 32'd1);
    issue(OP_SUB, 32'd7, 32'd7);
    wait_done(10, cyc, bcnt);
    chk("sub0_res", result, 32'd0);
    chk("sub0_zero", 32'(zero), 32'd1);
    chk("sub0_ovf", 32'(overflow), 32'd0);

    // ADD positive overflow
    issue(OP_ADD, 32'h7FFFFFFF, 32'd1);
    wait_done(10, cyc, bcnt);
    chk("addov_res", result, 32'h80000000);
    chk("addov_ovf", 32'(overflow), 32'd1);

    // SHIFT 1<<4
    issue(OP_SHIFT, 32'd1, 32'd4);
    wait_done(40, cyc, bcnt);
    chk("sh4_lat", cyc, 32'd5);
    chk("sh4_busy", bcnt, 32'd4);
    chk("sh4_res", result, 32'h10);

    // SHIFT 1<<31
    issue(OP_SHIFT, 32'd1, 32'd31);
    wait_done(40, cyc, bcnt);
    chk("sh31_lat", cyc, 32'd32);
    chk("sh31_busy", bcnt, 32'd31);
    chk("sh31_res", result, 32'h80000000);

    // SHIFT by 0 (upper src2 bits ignored)
    issue(OP_SHIFT, 32'hDEADBEEF, 32'hFFFFFFE0);
    wait_done(10, cyc, bcnt);
    chk("sh0_lat", cyc, 32'd1);
    chk("sh0_res", result, 32'hDEADBEEF);
    chk("sh0_ovf", 32'(overflow), 32'd0);

    // start during SHIFT k=8 is ignored
    issue(OP_SHIFT, 32'h3, 32'd8);
    dcnt = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        chk("ign_res", result, 32'h300);
      end
      if (i == 2) begin start = 1'b1; fn = OP_ADD; src1 = 32'h12345678; src2 = 32'd1; end
      if (i == 4) start = 1'b0;
    end
    chk("ign_done_cnt", dcnt, 32'd1);

    // Back-to-back: OR accepted in the shift's done cycle
    issue(OP_SHIFT, 32'd1, 32'd2);
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b1; fn = OP_OR; src1 = 32'hF0; src2 = 32'h0F;
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_res1", result, 32'd4);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_res2", result, 32'hFF);

    // Reset during the 3rd cycle of SHIFT k=10
    issue(OP_SHIFT, 32'd1, 32'd10);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", 32'(zero), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("arst_no_done", dcnt, 32'd0);

    // Randomized traffic, inputs changing every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      fn    = 2'($urandom_range(0, 3));
      src1  = pick();
      src2  = pick();
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
